// File: rtl/mac_result_drain.sv
// Buffers whole MAC-array result vectors and serializes them lane by lane onto a valid/ready stream.
// Optional macro MAC_DRAIN_CNT_EN adds vec_cnt_o, a count of fully drained vectors.
module mac_result_drain #(
  parameter int DATA_WIDTH = 16,
  parameter int ARRAY_ROWS = 16,
  parameter int VEC_DEPTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 cap_valid_i,
  input  logic [DATA_WIDTH*ARRAY_ROWS-1:0]     mac_result_i,
  output logic                                 cap_ready_o,
  input  logic                                 flush_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic [DATA_WIDTH-1:0]                out_data_o,
  output logic [$clog2(ARRAY_ROWS)-1:0]        out_lane_o,
  output logic                                 out_last_o,
  output logic                                 overflow_o,
  output logic [$clog2(VEC_DEPTH):0]           level_o
`ifdef MAC_DRAIN_CNT_EN
  ,
  output logic [31:0]                          vec_cnt_o
`endif
);

  localparam int PW = $clog2(VEC_DEPTH) + 1;
  localparam int IW = PW - 1;
  localparam int LW = $clog2(ARRAY_ROWS);
  localparam int VW = DATA_WIDTH * ARRAY_ROWS;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   lane_cnt_q;
  logic [VW-1:0]   mem_q [VEC_DEPTH];
  logic [VW-1:0]   head_vec;
  logic [DATA_WIDTH-1:0] head_lanes [ARRAY_ROWS];
  logic            full, empty, push, pop_word, last_lane, pop_vec, overflow_q;
  logic [PW-1:0]   level;

  assign full      = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign level     = wr_ptr_q - rd_ptr_q;
  assign push      = cap_valid_i && !full && !flush_i;
  assign pop_word  = (state_q == STREAM) && out_ready_i && !flush_i;
  assign last_lane = (lane_cnt_q == LW'(ARRAY_ROWS - 1));
  assign pop_vec   = pop_word && last_lane;

  assign cap_ready_o = !full;
  assign overflow_o  = overflow_q;
  assign level_o     = level;

  assign head_vec = mem_q[rd_ptr_q[IW-1:0]];
  for (genvar r = 0; r < ARRAY_ROWS; r++) begin : g_lanes
    assign head_lanes[r] = head_vec[r*DATA_WIDTH +: DATA_WIDTH];
  end

  // Vector storage carries no reset; it is only observed through the STREAM state.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[IW-1:0]] <= mac_result_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lane_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      lane_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_word) begin
        if (last_lane) begin
          lane_cnt_q <= '0;
          rd_ptr_q   <= rd_ptr_q + PW'(1);
        end else begin
          lane_cnt_q <= lane_cnt_q + LW'(1);
        end
      end
      if (cap_valid_i && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Leaving STREAM only when the sole stored vector finishes and nothing replaces it.
  always_comb begin
    state_d     = state_q;
    out_valid_o = 1'b0;
    out_data_o  = '0;
    out_lane_o  = '0;
    out_last_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (push) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        out_valid_o = 1'b1;
        out_data_o  = head_lanes[lane_cnt_q];
        out_lane_o  = lane_cnt_q;
        out_last_o  = last_lane;
        if (pop_vec && (level == PW'(1)) && !push) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush_i) begin
      state_d = IDLE;
    end
    if (empty && !push) begin
      state_d = IDLE;
    end
  end

`ifdef MAC_DRAIN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_cnt_o <= '0;
    end else if (flush_i) begin
      vec_cnt_o <= '0;
    end else if (pop_vec) begin
      vec_cnt_o <= vec_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/mac_result_drain.md
Name: mac_result_drain

Overview:
Drains the parallel result vector of the PE-core MAC array and serializes it into a single-word valid/ready stream toward the writeback path. Captures one full ARRAY_ROWS-lane vector per strobe into a small vector FIFO, then emits lanes 0..ARRAY_ROWS-1 in order with a last marker. Sits between the MAC array's mac_result outputs and the PE output buffer, providing backpressure isolation for the array.

Parameters:
DATA_WIDTH, 16, width of one result lane.
ARRAY_ROWS, 16, lanes per result vector (matches MAC array rows).
VEC_DEPTH, 4, number of whole vectors buffered; power of two, >= 2.

Ports:
clk  input  1  clock, all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
cap_valid_i  input  1  mac_result_i holds a new vector this cycle; driven the cycle after the array's enable.
mac_result_i  input  DATA_WIDTH*ARRAY_ROWS  flattened result vector; lane r at bits [r*DATA_WIDTH +: DATA_WIDTH].
cap_ready_o  output  1  FIFO not full; a capture is accepted only when high.
flush_i  input  1  synchronous clear of FIFO, lane counter and overflow flag.
out_valid_o  output  1  out_data_o is valid.
out_ready_i  input  1  downstream accepts the word.
out_data_o  output  DATA_WIDTH  current lane word.
out_lane_o  output  $clog2(ARRAY_ROWS)  lane index of out_data_o.
out_last_o  output  1  high with the final lane (ARRAY_ROWS-1) of a vector.
overflow_o  output  1  sticky: a capture was dropped because the FIFO was full.
level_o  output  $clog2(VEC_DEPTH)+1  number of vectors stored (including the one being drained).

Behaviour:
- Reset: FIFO empty, wr/rd pointers 0, lane counter 0, cap_ready_o=1, out_valid_o=0, out_data_o=0, out_lane_o=0, out_last_o=0, overflow_o=0, level_o=0.
- Storage: VEC_DEPTH x (DATA_WIDTH*ARRAY_ROWS) register array; pointers are $clog2(VEC_DEPTH)+1 bits, MSB is the wrap bit. full = same index and different wrap bit; empty = pointers equal.
- Capture: push when cap_valid_i && cap_ready_o. cap_ready_o = !full, from registered state only. No bypass: a push is refused when full, even if the last lane pops in the same cycle.
- Drop: cap_valid_i while full writes nothing; overflow_o sets on the next edge and holds until flush_i or reset.
- FSM, 2 states:
  - IDLE (empty): out_valid_o=0.
  - STREAM: out_valid_o=1; out_data_o = head vector lane[lane_cnt]; out_lane_o = lane_cnt; out_last_o = (lane_cnt==ARRAY_ROWS-1).
- Transitions:
  - IDLE->STREAM on the edge after the first push.
  - In STREAM, a handshake (out_valid_o && out_ready_i) increments lane_cnt. On the last lane, lane_cnt wraps to 0 and rd_ptr increments; the state returns to IDLE if that vector was the only one stored and no push occurs in the same cycle, else stays in STREAM.
- Latency: vector captured at edge N gives lane 0 valid in cycle N+1. Back-to-back vectors stream with no idle cycle between last lane and next lane 0.
- out_data_o / out_lane_o stay stable while out_valid_o && !out_ready_i. Output words are combinational from registered state, with no combinational path from out_ready_i.
- Simultaneous push and pop (not full): both take effect; level_o unchanged if the pop completed a vector.
- flush_i: highest priority over push and pop. Next cycle: empty, IDLE, lane_cnt=0, overflow_o=0. A capture in the flush cycle is discarded and does not set overflow_o.
- Reset mid-stream: immediate return to reset values; the partial vector is lost.
- level_o = wr_ptr - rd_ptr, modulo pointer width.

Optional Feature:
MAC_DRAIN_CNT_EN:
- Defined: adds output vec_cnt_o [31:0], the count of vectors fully drained (incremented on the out_last_o handshake). Reset to 0, cleared by flush_i, wraps at 2^32.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
ARRAY_ROWS=4, DATA_WIDTH=16, VEC_DEPTH=2 unless noted.
- Single vector {0x0004,0x0003,0x0002,0x0001} (lane0=0x0001) with out_ready_i=1: lanes 0..3 emit 0x0001..0x0004 in cycles N+1..N+4; out_last_o only with 0x0004; then IDLE, level_o=0.
- Backpressure: out_ready_i low 3 cycles at lane 2: out_data_o holds 0x0003 and out_lane_o=2 stable; then it resumes; no lane skipped or duplicated.
- Full/drop: three captures on consecutive cycles with out_ready_i=0: first two accepted, level_o=2, cap_ready_o=0, third dropped, overflow_o=1; draining emits exactly 8 words, from vectors 1 and 2.
- Pop-while-full: FIFO full, last-lane handshake and cap_valid_i in the same cycle: capture refused (overflow_o=1); the next cycle cap_ready_o=1.
- Flush mid-stream at lane 1 with a capture in the same cycle: the next cycle out_valid_o=0, level_o=0, overflow_o=0, and a new vector restarts at lane 0.
- With MAC_DRAIN_CNT_EN: after 5 vectors are drained, vec_cnt_o=5; after flush_i, vec_cnt_o=0.
